instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the grupal processor pipeline, directly upstream of the decode stage. Owns the program counter, drives a synchronous instruction memory with a fixed 1-cycle read latency, and delivers one 32-bit instruction per cycle, tagged with its PC, into the fetch/decode pipeline register. It honours a stall from decode and a taken-branch redirect from execute. A 1-entry skid buffer guarantees that no fetched word is lost or duplicated.

## Interface
- `ADDR_W`, 16: PC and instruction-memory word-address width.
- `RESET_PC`, 0: first fetch address after reset.

- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: decode cannot accept; output register holds.
- `branch_taken`  in  1: redirect request from execute (b, beq).
- `branch_target`  in  ADDR_W: new PC when `branch_taken`=1.
- `imem_addr`  out  ADDR_W: word address, equal to the current PC (combinational).
- `imem_rd_en`  out  1: read strobe; data returns on the next cycle.
- `imem_rdata`  in  32: memory data, valid the cycle after `imem_rd_en`.
- `instruction`  out  32: instruction presented to decode.
- `instr_pc`  out  ADDR_W: address of `instruction`.
- `instr_valid`  out  1: `instruction` is a real fetched word.

## Operation
- FSM states: IDLE, RUN.
  - Reset forces IDLE.
  - IDLE -> RUN unconditionally on the next cycle.
  - RUN stays in RUN.
- `imem_rd_en` = (state==RUN) && !stall && !branch_taken.
- PC update:
  - `pc <= pc+1` on each issued read. Arithmetic is modulo 2^ADDR_W, so the top address wraps to 0.
  - `branch_taken` loads `pc <= branch_target`, with priority over everything except `reset`.
- In-flight tracking: `pend <= imem_rd_en`, and `pend_pc <= pc` at issue. The response is consumed the following cycle.
- Output register update when `stall`=0:
  - If the skid buffer is full, load its entry and empty the buffer.
  - Otherwise, if `pend`=1, load `imem_rdata`/`pend_pc`.
  - Otherwise, `instr_valid <= 0`.
- When `stall`=1 and `pend`=1: capture the response into the skid buffer. The buffer is provably empty in this case, because reads are suppressed while stalled.
- `branch_taken`=1 (regardless of `stall`):
  - drop `pend` (the response is ignored);
  - clear the skid buffer;
  - clear `instr_valid`;
  - force `instruction` to NOP (all zero).
- `instruction` is zero whenever `instr_valid`=0.

## Timing
- Reset values:
  - pc = RESET_PC; state = IDLE; pend = 0; skid empty.
  - `instruction` = 0, `instr_pc` = 0, `instr_valid` = 0, `imem_rd_en` = 0.
  - `imem_addr` = RESET_PC.
- Startup: reset released at cycle 0 → first `imem_rd_en` at cycle 1 → first `instr_valid` at cycle 2.
- Steady state: 1 instruction per cycle. Latency is 2 cycles from PC to output register.
- Stall at cycle t:
  - output frozen from t;
  - no read issued at t;
  - a read issued at t-1 goes to the skid buffer.
- Stall release at cycle u:
  - output takes the skid entry at u;
  - a read is issued at u;
  - its word is output at u+1.
  - No bubble and no duplicate.
- Branch at cycle t:
  - no read at t;
  - `imem_addr` = target with a read at t+1;
  - target instruction valid at t+2.
  - The two wrong-path slots show `instr_valid`=0.
- Branch and stall in the same cycle: the branch wins, and the stall only delays the next issue.
- Reset mid-stream (including mid-stall or mid-branch): all state returns to reset values on that edge. Any in-flight response is discarded.

## Structure
- Package `isa_pkg`, shared with decode/execute:
  - `INSTR_W`=32;
  - opcode field [31:27] and typedef `opcode_t` (5 bits);
  - opcode constants LV=1, arithmetic 2–5, CP=6, B=7, BEQ=8, SLR=9, GP=10;
  - operand field slices [26:18], [17:9], [8:0];
  - `NOP`=32'h0.
- Sub-module `fetch_skid_buffer`:
  - 1-entry {data, pc, full} holding register;
  - push, pop and clear inputs;
  - instantiated once.
- FSM state typedef local to `instruction_fetch`.

## Test plan
- Reset release with memory word i = 32'h1000_0000+i: `instr_valid` rises at cycle 2 with `instr_pc`=0. Then PCs 1, 2, 3… appear on consecutive cycles.
- `stall` high for 3 cycles mid-stream while PC 5 is in flight: output holds PC 4, then releases. The sequence continues 5, 6, 7 with no gaps or repeats; `imem_rd_en`=0 during the stall.
- `branch_taken` with target 0x0040 at PC 8: PCs 9/10 never become valid. Next valid `instr_pc`=0x0040, exactly 2 cycles later.
- `branch_taken` asserted while `stall`=1 and the skid buffer full: the skid is cleared and the target is fetched. The stale word never appears.
- `ADDR_W`=4 with PC reaching 15: next `instr_pc`=0 with no gap.
- `reset` pulsed for 1 cycle during a stall with the skid buffer full: outputs are zero the next cycle. Fetch restarts at RESET_PC with the cycle-2 timing.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the grupal pipeline: instruction width, opcode
// encodings and operand field positions used by fetch, decode and execute.
package isa_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_LV  = 5'd1;
  localparam opcode_t OP_ADD = 5'd2;
  localparam opcode_t OP_SUB = 5'd3;
  localparam opcode_t OP_AND = 5'd4;
  localparam opcode_t OP_OR  = 5'd5;
  localparam opcode_t OP_CP  = 5'd6;
  localparam opcode_t OP_B   = 5'd7;
  localparam opcode_t OP_BEQ = 5'd8;
  localparam opcode_t OP_SLR = 5'd9;
  localparam opcode_t OP_GP  = 5'd10;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned OPA_HI = 26;
  localparam int unsigned OPA_LO = 18;
  localparam int unsigned OPB_HI = 17;
  localparam int unsigned OPB_LO = 9;
  localparam int unsigned OPC_OPND_HI = 8;
  localparam int unsigned OPC_OPND_LO = 0;

  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  function automatic opcode_t opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register that parks a memory response arriving while
// decode is stalled, so the word is neither lost nor re-fetched.
module fetch_skid_buffer
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] push_data,
  input  logic [ADDR_W-1:0]  push_pc,
  output logic               full,
  output logic [INSTR_W-1:0] data,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clock) begin
    if (clear) begin
      full <= 1'b0;
      data <= '0;
      pc   <= '0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
      pc   <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle synchronous instruction
// memory and feeds the fetch/decode register, honouring stall and redirect.
module instruction_fetch
  import isa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pend_pc;
  logic               pend;

  logic               skid_full;
  logic [INSTR_W-1:0] skid_data;
  logic [ADDR_W-1:0]  skid_pc;
  logic               skid_push;
  logic               skid_pop;
  logic               skid_clear;

  assign imem_addr  = pc;
  assign imem_rd_en = (state == RUN) && !stall && !branch_taken;

  // Reads are suppressed while stalled, so a push always finds the buffer empty.
  assign skid_push  = stall && pend && !branch_taken;
  assign skid_pop   = !stall && skid_full && !branch_taken;
  assign skid_clear = reset || branch_taken;

  fetch_skid_buffer #(
    .ADDR_W(ADDR_W)
  ) u_skid (
    .clock     (clock),
    .clear     (skid_clear),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data (imem_rdata),
    .push_pc   (pend_pc),
    .full      (skid_full),
    .data      (skid_data),
    .pc        (skid_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend        <= 1'b0;
      pend_pc     <= '0;
      instruction <= NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= RUN;
      if (branch_taken) begin
        pc          <= branch_target;
        pend        <= 1'b0;
        instruction <= NOP;
        instr_valid <= 1'b0;
      end else begin
        pend <= imem_rd_en;
        if (imem_rd_en) begin
          pc      <= pc + 1'b1;
          pend_pc <= pc;
        end
        if (!stall) begin
          if (skid_full) begin
            instruction <= skid_data;
            instr_pc    <= skid_pc;
            instr_valid <= 1'b1;
          end else if (pend) begin
            instruction <= imem_rdata;
            instr_pc    <= pend_pc;
            instr_valid <= 1'b1;
          end else begin
            instruction <= NOP;
            instr_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a 16-bit and a 4-bit address instance share
// one stimulus stream and are compared against a word-queue reference model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] target16;
  logic [3:0]  target4;

  logic [15:0] addr16;
  logic        rd16;
  logic [31:0] rdata16;
  logic [31:0] instr16;
  logic [15:0] ipc16;
  logic        valid16;

  logic [3:0]  addr4;
  logic        rd4;
  logic [31:0] rdata4;
  logic [31:0] instr4;
  logic [3:0]  ipc4;
  logic        valid4;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0)) u_dut16 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(target16), .imem_addr(addr16), .imem_rd_en(rd16),
    .imem_rdata(rdata16), .instruction(instr16), .instr_pc(ipc16),
    .instr_valid(valid16)
  );

  instruction_fetch #(.ADDR_W(4), .RESET_PC(4'h0)) u_dut4 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(target4), .imem_addr(addr4), .imem_rd_en(rd4),
    .imem_rdata(rdata4), .instruction(instr4), .instr_pc(ipc4),
    .instr_valid(valid4)
  );

  // Instruction memory contents: word at address a is 32'h1000_0000 + a.
  always @(posedge clock) if (rd16) rdata16 <= 32'h1000_0000 + {16'h0, addr16};
  always @(posedge clock) if (rd4)  rdata4  <= 32'h1000_0000 + {28'h0, addr4};

  // Reference model: next PC plus a FIFO of fetched words not yet delivered.
  bit          m_started [2];
  logic [15:0] m_pc      [2];
  bit          m_ov      [2];
  logic [31:0] m_od      [2];
  logic [15:0] m_opc     [2];
  logic [15:0] q_pc      [2][4];
  logic [31:0] q_d       [2][4];
  int          q_cnt     [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic [15:0] mask, input logic rst,
                            input logic st, input logic br, input logic [15:0] tgt);
    if (rst) begin
      m_started[i] = 0;
      m_pc[i] = 16'h0;
      q_cnt[i] = 0;
      m_ov[i] = 0;
      m_od[i] = 32'h0;
      m_opc[i] = 16'h0;
    end else if (br) begin
      m_started[i] = 1;
      m_pc[i] = tgt & mask;
      q_cnt[i] = 0;
      m_ov[i] = 0;
      m_od[i] = 32'h0;
    end else begin
      if (!st) begin
        if (q_cnt[i] > 0) begin
          m_ov[i] = 1;
          m_od[i] = q_d[i][0];
          m_opc[i] = q_pc[i][0];
          for (int k = 0; k < 3; k++) begin
            q_d[i][k] = q_d[i][k+1];
            q_pc[i][k] = q_pc[i][k+1];
          end
          q_cnt[i]--;
        end else begin
          m_ov[i] = 0;
          m_od[i] = 32'h0;
        end
      end
      if (m_started[i] && !st) begin
        q_pc[i][q_cnt[i]] = m_pc[i];
        q_d[i][q_cnt[i]] = 32'h1000_0000 + {16'h0, m_pc[i]};
        q_cnt[i]++;
        m_pc[i] = (m_pc[i] + 16'h1) & mask;
      end
      m_started[i] = 1;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic br, input logic [15:0] tgt);
    logic exp_rd0;
    logic exp_rd1;
    reset = rst;
    stall = st;
    branch_taken = br;
    target16 = tgt;
    target4 = tgt[3:0];
    #1;
    if (!rst) begin
      exp_rd0 = m_started[0] && !st && !br;
      exp_rd1 = m_started[1] && !st && !br;
      check_eq("rd_en16", {31'h0, rd16}, {31'h0, exp_rd0});
      check_eq("addr16", {16'h0, addr16}, {16'h0, m_pc[0]});
      check_eq("rd_en4", {31'h0, rd4}, {31'h0, exp_rd1});
      check_eq("addr4", {28'h0, addr4}, {16'h0, m_pc[1]});
    end
    @(posedge clock);
    #1;
    model_step(0, 16'hFFFF, rst, st, br, tgt);
    model_step(1, 16'h000F, rst, st, br, tgt);
    check_eq("valid16", {31'h0, valid16}, {31'h0, m_ov[0]});
    check_eq("instr16", instr16, m_od[0]);
    if (m_ov[0] || rst) check_eq("ipc16", {16'h0, ipc16}, {16'h0, m_opc[0]});
    check_eq("valid4", {31'h0, valid4}, {31'h0, m_ov[1]});
    check_eq("instr4", instr4, m_od[1]);
    if (m_ov[1] || rst) check_eq("ipc4", {28'h0, ipc4}, {16'h0, m_opc[1]});
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    target16 = 16'h0;
    target4 = 4'h0;
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 0;
      q_cnt[i] = 0;
    end
    @(posedge clock);
    #1;

    // Reset, then startup: read at edge 1, first valid word (PC 0) at edge 2.
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    check_eq("startup_valid", {31'h0, valid16}, 32'h1);
    check_eq("startup_pc", {16'h0, ipc16}, 32'h0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 16'h0);
    check_eq("pre_stall_pc", {16'h0, ipc16}, 32'h4);

    // Three-cycle stall with PC 5 in flight.
    for (int k = 0; k < 3; k++) step(0, 1, 0, 16'h0);
    check_eq("stall_hold_pc", {16'h0, ipc16}, 32'h4);
    step(0, 0, 0, 16'h0);
    check_eq("release_pc", {16'h0, ipc16}, 32'h5);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 16'h0);
    check_eq("pre_branch_pc", {16'h0, ipc16}, 32'h8);

    // Redirect to 0x0040; wrong-path slots stay invalid.
    step(0, 0, 1, 16'h0040);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    check_eq("branch_target_pc", {16'h0, ipc16}, 32'h40);
    for (int k = 0; k < 14; k++) step(0, 0, 0, 16'h0);

    // Branch while stalled with the skid full; stall persists one more cycle.
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h0100);
    step(0, 1, 0, 16'h0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 16'h0);

    // One-cycle reset during a stall with the skid full.
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    check_eq("midreset_valid", {31'h0, valid16}, 32'h0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 16'h0);

    // Random mix of stalls, branches and occasional resets.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 2, $urandom_range(0, 99) < 30, (r >= 2) && (r < 12), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
